// File: rtl/seg_scan_driver_if.sv
// Value handshake into the seven-segment scan driver.
// The producer holds value_in/value_valid until value_ready accepts it.
interface seg_scan_driver_if;
    logic [7:0] value_in;
    logic       value_valid;
    logic       value_ready;

    modport master (
        output value_in,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output value_ready
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with blanking gaps.
// New values are latched only at frame boundaries.
module seg_scan_driver #(
    parameter int PRESCALE     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   vin,
    input  logic               blank_lz,
    output logic [6:0]         seg,
    output logic [1:0]         an,
    output logic               frame_done
);

    localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LD  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LD =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        SHOW_LO,
        BLANK_LO,
        SHOW_HI,
        BLANK_HI
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          boundary;
    logic [7:0]    disp_reg;
    logic [7:0]    pend_reg;
    logic          pend_full;
    logic          hi_blank;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] r;
        r = 7'h00;
        case (d)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            4'hF: r = 7'h71;
        endcase
        return r;
    endfunction

    // Counter runs down; each state ends when it reaches zero.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt - CW'(1);
        boundary = 1'b0;
        if (cnt == '0) begin
            unique case (state)
                SHOW_LO: begin
                    if (BLANK_CYCLES > 0) begin
                        state_n = BLANK_LO;
                        cnt_n   = BLANK_LD;
                    end else begin
                        state_n = SHOW_HI;
                        cnt_n   = SHOW_LD;
                    end
                end
                BLANK_LO: begin
                    state_n = SHOW_HI;
                    cnt_n   = SHOW_LD;
                end
                SHOW_HI: begin
                    if (BLANK_CYCLES > 0) begin
                        state_n = BLANK_HI;
                        cnt_n   = BLANK_LD;
                    end else begin
                        state_n  = SHOW_LO;
                        cnt_n    = SHOW_LD;
                        boundary = 1'b1;
                    end
                end
                BLANK_HI: begin
                    state_n  = SHOW_LO;
                    cnt_n    = SHOW_LD;
                    boundary = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK_HI;
            cnt        <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_full  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            frame_done <= boundary;
            // Accept and load are exclusive: accept needs an empty slot.
            if (boundary && pend_full) begin
                disp_reg  <= pend_reg;
                pend_full <= 1'b0;
            end else if (vin.value_valid && !pend_full) begin
                pend_reg  <= vin.value_in;
                pend_full <= 1'b1;
            end
        end
    end

    assign vin.value_ready = ~pend_full;
    assign hi_blank = blank_lz && (disp_reg[7:4] == 4'h0);

    always_comb begin
        an  = 2'b11;
        seg = 7'h00;
        unique case (state)
            SHOW_LO: begin
                an  = 2'b10;
                seg = hex7(disp_reg[3:0]);
            end
            SHOW_HI: begin
                if (!hi_blank) begin
                    an  = 2'b01;
                    seg = hex7(disp_reg[7:4]);
                end
            end
            default: begin
                an  = 2'b11;
                seg = 7'h00;
            end
        endcase
    end

endmodule
